// File: rtl/sigdel_cic_decimator.sv
// N-th order CIC (sinc^N) decimator for a 1-bit sigma-delta stream, power-of-two ratio.
// Optional start-up transient suppression: define SIGDEL_DECIM_WARMUP_EN.
module sigdel_cic_decimator #(
   parameter int order           = 3,
   parameter int decim_log2      = 6,
   parameter int output_bitwidth = 24
) (
   input  logic                              mod_clock,
   input  logic                              reset,
   input  logic                              bit_en,
   input  logic                              bit_in,
   output logic signed [output_bitwidth-1:0] data_out,
   output logic                              data_valid
);

   localparam int W  = order * decim_log2 + 2;
   localparam int S  = output_bitwidth - 1 - order * decim_log2;
   localparam int SL = (S > 0) ? S : 0;
   localparam int SR = (S < 0) ? -S : 0;
   localparam int EW = W + SL + output_bitwidth;

   // Align the comb result to output full scale, then clip; only +R^N can exceed the range.
   function automatic logic signed [output_bitwidth-1:0] scale_sat(input logic signed [W-1:0] v);
      logic signed [EW-1:0] ext;
      logic signed [EW-1:0] maxv;
      logic signed [EW-1:0] minv;
      ext  = {{(EW-W){v[W-1]}}, v};
      ext  = (ext <<< SL) >>> SR;
      maxv = '0;
      maxv[output_bitwidth-2:0] = '1;
      minv = ~maxv;
      if (ext > maxv)
         return maxv[output_bitwidth-1:0];
      else if (ext < minv)
         return minv[output_bitwidth-1:0];
      else
         return ext[output_bitwidth-1:0];
   endfunction

   logic signed [W-1:0] x_in;
   assign x_in = bit_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

   // Integrator stage: sums chain combinationally so the last stage includes the current bit
   genvar k;
   for (k = 0; k < order; k++) begin : g_int
      logic signed [W-1:0] acc;
      logic signed [W-1:0] sum;
      if (k == 0) begin : g_first
         assign sum = acc + x_in;
      end else begin : g_rest
         assign sum = acc + g_int[k-1].sum;
      end
      always_ff @(posedge mod_clock) begin
         if (reset)
            acc <= '0;
         else if (bit_en)
            acc <= sum;
      end
   end

   logic [decim_log2-1:0] phase;
   logic                  strobe;
   logic signed [W-1:0]   stage_p [order+1];
   logic signed [W-1:0]   dly [order];
   logic [order:0]        vld_p;

   assign strobe = bit_en && (phase == '1);

   // Decimation register (p0) and comb stages p1..pN, each advancing with its token
   always_ff @(posedge mod_clock) begin
      if (reset) begin
         phase <= '0;
         vld_p <= '0;
         for (int i = 0; i <= order; i++) stage_p[i] <= '0;
         for (int i = 0; i < order; i++) dly[i] <= '0;
      end else begin
         if (bit_en) phase <= phase + 1'b1;
         vld_p[0] <= strobe;
         if (strobe) stage_p[0] <= g_int[order-1].sum;
         for (int i = 1; i <= order; i++) begin
            vld_p[i] <= vld_p[i-1];
            if (vld_p[i-1]) begin
               stage_p[i] <= stage_p[i-1] - dly[i-1];
               dly[i-1]   <= stage_p[i-1];
            end
         end
      end
   end

   logic emit;
`ifdef SIGDEL_DECIM_WARMUP_EN
   localparam int WCW = $clog2(order + 1);
   logic [WCW-1:0] warm_cnt;
   logic           warm_done;
   assign warm_done = (warm_cnt == WCW'(order));
   assign emit      = vld_p[order] && warm_done;

   always_ff @(posedge mod_clock) begin
      if (reset)
         warm_cnt <= '0;
      else if (vld_p[order] && !warm_done)
         warm_cnt <= warm_cnt + 1'b1;
   end
`else
   assign emit = vld_p[order];
`endif

   // Output stage
   always_ff @(posedge mod_clock) begin
      if (reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= emit;
         if (emit) data_out <= scale_sat(stage_p[order]);
      end
   end

endmodule

// File: tb/tb_sigdel_cic_decimator.sv
// Directed bench for sigdel_cic_decimator at default parameters (order 3, R 64, 24-bit out).
module tb_sigdel_cic_decimator;

   logic               mod_clock = 1'b0;
   logic               reset     = 1'b1;
   logic               bit_en    = 1'b0;
   logic               bit_in    = 1'b0;
   logic signed [23:0] data_out;
   logic               data_valid;

   sigdel_cic_decimator #(
      .order(3),
      .decim_log2(6),
      .output_bitwidth(24)
   ) dut (
      .mod_clock (mod_clock),
      .reset     (reset),
      .bit_en    (bit_en),
      .bit_in    (bit_in),
      .data_out  (data_out),
      .data_valid(data_valid)
   );

`ifdef SIGDEL_DECIM_WARMUP_EN
   localparam bit WARM = 1'b1;
`else
   localparam bit WARM = 1'b0;
`endif

   always #5 mod_clock = ~mod_clock;

   int unsigned cyc = 0;
   always @(posedge mod_clock) cyc <= cyc + 1;

   // Edge index and value of every data_valid strobe
   int unsigned vq[$];
   logic [23:0] dq[$];
   always @(negedge mod_clock) begin
      if (data_valid) begin
         vq.push_back(cyc);
         dq.push_back(data_out);
      end
   end

   int n_chk = 0;
   int n_err = 0;
   int unsigned rel;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge mod_clock); #2;
      reset  = 1'b1;
      bit_en = 1'b0;
      bit_in = 1'b0;
      repeat (2) @(posedge mod_clock);
      #2;
      chk("rst_data_out", {data_out}, 0);
      chk("rst_data_valid", {data_valid}, 0);
      vq.delete();
      dq.delete();
      reset = 1'b0;
      rel   = cyc;
   endtask

   // pat[j] is the j-th accepted bit, repeating every plen bits
   task automatic run_stream(input logic [3:0] pat, input int plen, input bit toggle, input int ncyc);
      int bi = 0;
      for (int i = 0; i < ncyc; i++) begin
         bit_en = toggle ? (i % 2 == 0) : 1'b1;
         bit_in = pat[bi % plen];
         if (bit_en) bi++;
         @(posedge mod_clock); #2;
      end
      bit_en = 1'b0;
      @(negedge mod_clock); #1;
   endtask

   task automatic check_stream(input string tag, input logic [3:0] pat, input int plen,
                               input bit toggle, input logic [23:0] expv);
      int per;
      int first;
      int exp_cnt;
      per     = toggle ? 128 : 64;
      first   = (toggle ? (WARM ? 511 : 127) : (WARM ? 256 : 64)) + 4;
      exp_cnt = (1000 - first) / per + 1;
      do_reset();
      run_stream(pat, plen, toggle, 1000);
      chk({tag, "_count"}, vq.size(), exp_cnt);
      if (vq.size() > 0) chk({tag, "_first"}, vq[0] - rel, first);
      for (int i = 1; i < vq.size(); i++) chk({tag, "_spacing"}, vq[i] - vq[i-1], per);
      for (int i = (WARM ? 0 : 3); i < dq.size(); i++) chk({tag, "_value"}, dq[i], expv);
   endtask

   int unsigned rel2;

   initial begin
      check_stream("ones",   4'b0001, 1, 1'b0, 24'h7FFFFF);
      check_stream("zeros",  4'b0000, 1, 1'b0, 24'h800000);
      check_stream("alt10",  4'b0001, 2, 1'b0, 24'h000000);
      check_stream("p1110",  4'b0111, 4, 1'b0, 24'h400000);
      check_stream("ones_en_toggle", 4'b0001, 1, 1'b1, 24'h7FFFFF);

      // Reset two clocks after strobe 5: its token must never appear
      do_reset();
      run_stream(4'b0001, 1, 1'b0, 321);
      chk("pre_reset_count", vq.size(), WARM ? 1 : 4);
      chk("pre_reset_data", {data_out}, 24'h7FFFFF);
      reset = 1'b1;
      repeat (2) @(posedge mod_clock);
      #2;
      chk("mid_reset_data_out", {data_out}, 0);
      chk("mid_reset_data_valid", {data_valid}, 0);
      vq.delete();
      dq.delete();
      reset = 1'b0;
      rel2  = cyc;
      run_stream(4'b0001, 1, 1'b0, 100);
      chk("post_reset_count", vq.size(), WARM ? 0 : 1);
      if (vq.size() > 0) chk("post_reset_first", vq[0] - rel2, 68);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sigdel_cic_decimator.md
# sigdel_cic_decimator

Decimation stage that consumes the 1-bit stream of the first-order sigma-delta modulator and reconstructs multi-bit PCM samples. It sits directly downstream of the modulator, on the same modulator clock, and applies an N-th order CIC (sinc^N) decimator with a power-of-two ratio. The filter is scaled so that modulator full scale maps back to the 24-bit full-scale code, and it emits one sample with a single-cycle valid strobe per decimation period.

## Interface
- order, 3: CIC order N, legal range 1..5.
- decim_log2, 6: log2 of the decimation ratio R, so R = 2^decim_log2. Legal range 1..8.
- output_bitwidth, 24: width of the signed output sample.
- mod_clock  input  1  modulator clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_en  input  1  qualifies bit_in; the bit is consumed only on cycles where bit_en=1.
- bit_in  input  1  modulator output bit; 1 means +1 (positive full scale), 0 means -1.
- data_out  output  output_bitwidth  signed decimated sample. Held between strobes.
- data_valid  output  1  single-cycle strobe marking a new data_out.

## Operation
- Internal width W = order*decim_log2 + 2 bits, signed two's complement.
- Integrator and comb arithmetic wraps modulo 2^W; this wrap is intentional and required for CIC correctness. There is no saturation inside the filter.
- Input mapping: bit_in=1 gives +1, bit_in=0 gives -1, sign-extended to W bits.
- Integrator chain (N stages):
  - Stage 1 accumulates the mapped input; stage k accumulates the output of stage k-1.
  - All stages update only on cycles with bit_en=1.
- Phase counter:
  - Counts from 0 to R-1 on bit_en cycles and wraps to 0.
  - The bit_en cycle with counter = R-1 is the decimation strobe. On that edge, the value of the last integrator, including the current bit, is captured into the decimation register.
- Comb chain (N stages), pipelined:
  - Stage k computes x - x_delayed, with one delay register per stage.
  - Each stage advances only when its input token arrives, one token per strobe and one register stage per clock.
- Output scaling:
  - The comb result lies in [-R^N, +R^N]. Let s = output_bitwidth - 1 - order*decim_log2.
  - If s >= 0, the result is shifted left by s; if s < 0, it is shifted right arithmetically by -s (truncation).
  - The result is then saturated to [-2^(output_bitwidth-1), 2^(output_bitwidth-1) - 1]. Only +R^N can saturate.
- Defaults: W = 20, s = 5, R^N = 2^18.
  - All-ones input gives 0x7FFFFF after saturation.
  - All-zeros input gives 0x800000.
- Reset:
  - Integrators, combs, delay registers, phase counter, warm-up counter and pipeline tokens all clear to 0.
  - data_out resets to 0 and data_valid resets to 0.
  - Reset asserted mid-operation discards all in-flight tokens. No data_valid is issued from pre-reset data.
- Simultaneous events:
  - A new strobe while earlier tokens are still in the comb pipeline is legal whenever R >= 2 and needs no stall. The pipeline depth N+1 may exceed R.
  - Tokens never merge or drop.

## Timing
- Strobe accepted at edge t. Comb stage k registers at edge t+k. data_out and data_valid register at edge t+N+1. data_valid is high for exactly the cycle following edge t+N+1.
- Latency: N+1 clocks from the strobe edge to data_valid. This is independent of bit_en after the strobe, because the comb pipeline advances every clock.
- Output rate: one data_valid per R accepted bits.
- A first strobe occurs on the R-th bit_en cycle after reset release.
- bit_en=0 cycles freeze the integrators and the phase counter only.

## Configuration
- SIGDEL_DECIM_WARMUP_EN defined:
  - The first N output tokens after reset are computed but do not raise data_valid or update data_out, because they are the CIC start-up transient.
  - The first data_valid corresponds to strobe number N+1.
  - A warm-up counter of width ceil(log2(N+1)) saturates at N.
- SIGDEL_DECIM_WARMUP_EN undefined: every token raises data_valid, starting with strobe 1.

## Test plan
- Reset, then bit_in=1 held with bit_en=1 for 1000 cycles, default parameters -> the first valid sample is at cycle 64+4 (warm-up off). Every steady-state data_out = 0x7FFFFF. data_valid strobes are spaced exactly 64 clocks apart.
- Same as above with bit_in=0 -> steady-state data_out = 0x800000.
- Alternating 1,0,1,0 -> steady-state data_out = 0x000000. Repeating 1,1,1,0 -> 0x400000.
- bit_en toggled 1,0 every cycle with all-ones input -> the strobe period becomes 128 clocks. The latency from strobe to data_valid stays 4 clocks. The values are unchanged.
- Reset asserted 2 clocks after a strobe -> no data_valid for that token. data_out reads 0 the cycle after reset. Normal resumption: the first strobe is 64 bit_en cycles after release.
- Warm-up with SIGDEL_DECIM_WARMUP_EN defined -> the first data_valid occurs at strobe 4 (clock 4*64+4 = 260 with continuous bit_en), with no transient samples emitted.
